generation_ticker: RTL and testbench

Parametrised successor to the fixed 500 ms divided clock that paces the life-game generations and the LED counter.
- Runs entirely on the system clock and emits a one-cycle clock-enable pulse (tick) instead of a derived clock.
- Adds a switch-selectable rate, run/pause, single-step from a debounced button, synchronous clear, and a generation counter for the LEDs.
- Sits between the anti-jitter outputs and life_game; the top level drives life_game and the LED register with tick as an enable.

---
 rtl/life_game_pkg.sv | 14 +
 rtl/rising_edge_detector.sv | 23 ++
 rtl/generation_ticker.sv | 99 +++++++++
 tb/tb_generation_ticker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/life_game_pkg.sv
// Shared constants and helpers for the life-game pacing logic.
package life_game_pkg;

    // 500 ms at a 50 MHz system clock.
    localparam int unsigned DEFAULT_BASE_PERIOD = 25000000;
    localparam int unsigned DEFAULT_RATE_BITS   = 2;
    localparam int unsigned DEFAULT_COUNT_WIDTH = 8;

    // Tick period in clock cycles for a given speed select; each rate step halves the period.
    function automatic int unsigned rate_to_period(input int unsigned base, input int unsigned rate);
        return base >> rate;
    endfunction

endpackage

// File: rtl/rising_edge_detector.sv
// One-bit rising edge detector: registers the input every cycle and flags a 0->1 change.
// The edge output is combinational on d_i, so the consumer must register it.
module rising_edge_detector (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic edge_o
);

    logic d_q;

    // Previous-cycle copy of the input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign edge_o = d_i & ~d_q;

endmodule

// File: rtl/generation_ticker.sv
// Generation pacing: a prescaler on the system clock emits a one-cycle tick enable
// per generation, with selectable rate, run/pause, single-step and synchronous clear.
// Per-cycle priority: reset, clear, run, step. All outputs are registered.
module generation_ticker
    import life_game_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = DEFAULT_BASE_PERIOD,
    parameter int unsigned RATE_BITS   = DEFAULT_RATE_BITS,
    parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   step,
    input  logic                   clear,
    input  logic [RATE_BITS-1:0]   rate,
    output logic                   tick,
    output logic [COUNT_WIDTH-1:0] generation,
    output logic                   running
);

    // Derived from BASE_PERIOD; not meant to be overridden.
    localparam int unsigned PRESCALE_WIDTH = $clog2(BASE_PERIOD);

    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_ZERO = '0;
    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_ONE  = PRESCALE_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]    COUNT_ZERO    = '0;
    localparam logic [COUNT_WIDTH-1:0]    COUNT_ONE     = COUNT_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] prescaler_q, prescaler_d;
    logic [COUNT_WIDTH-1:0]    generation_q, generation_d;
    logic                      tick_q, tick_d;
    logic                      running_q, running_d;

    logic [31:0] period;
    logic        terminal;
    logic        step_edge;

    // The step button is already debounced; only its rising edge matters.
    rising_edge_detector u_step_edge (
        .clk_i  (clock),
        .rst_i  (reset),
        .d_i    (step),
        .edge_o (step_edge)
    );

    // Period follows the rate switches every cycle. Using >= rather than == means a
    // rate increase mid-count fires on the next cycle instead of wrapping the prescaler.
    always_comb begin
        period   = rate_to_period(BASE_PERIOD, 32'(rate));
        terminal = (32'(prescaler_q) >= (period - 32'd1));
    end

    // Next-state for prescaler, tick and generation counter in priority order.
    always_comb begin
        prescaler_d  = prescaler_q;
        tick_d       = 1'b0;
        generation_d = tick_q ? (generation_q + COUNT_ONE) : generation_q;
        running_d    = run;

        if (clear) begin
            // Drops any terminal count or step edge arriving in the same cycle.
            prescaler_d  = PRESCALE_ZERO;
            generation_d = COUNT_ZERO;
            tick_d       = 1'b0;
        end else if (run) begin
            // Free-running; step edges are ignored here.
            if (terminal) begin
                prescaler_d = PRESCALE_ZERO;
                tick_d      = 1'b1;
            end else begin
                prescaler_d = prescaler_q + PRESCALE_ONE;
            end
        end else begin
            // Paused: prescaler holds so a resume continues mid-period.
            tick_d = step_edge;
        end
    end

    // State registers; reset overrides every input, including clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler_q  <= PRESCALE_ZERO;
            generation_q <= COUNT_ZERO;
            tick_q       <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            generation_q <= generation_d;
            tick_q       <= tick_d;
            running_q    <= running_d;
        end
    end

    assign tick       = tick_q;
    assign generation = generation_q;
    assign running    = running_q;

endmodule

// File: tb/tb_generation_ticker.sv
// Bench for generation_ticker with BASE_PERIOD=16, RATE_BITS=2, COUNT_WIDTH=4.
// Stimulus pushes {tick cycle, generation shown during tick} entries into exp_q;
// a negedge monitor pops one entry per observed tick and flags late or extra ticks.
module tb_generation_ticker;

    logic       clock;
    logic       reset;
    logic       run;
    logic       step;
    logic       clear;
    logic [1:0] rate;
    logic       tick;
    logic [3:0] generation;
    logic       running;

    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    int          s;
    logic [3:0]  gen_model = 4'd0;
    logic [31:0] exp_q[$];

    generation_ticker #(
        .BASE_PERIOD (16),
        .RATE_BITS   (2),
        .COUNT_WIDTH (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .clear      (clear),
        .rate       (rate),
        .tick       (tick),
        .generation (generation),
        .running    (running)
    );

    // Clock and bench cycle count (cyc == k right after the k-th rising edge).
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expect a tick at cycle c; generation shows the pre-increment count during the tick.
    task automatic push_tick(input int c);
        exp_q.push_back({28'(c), gen_model});
        gen_model = gen_model + 4'd1;
    endtask

    // One-cycle clear; afterwards the prescaler is 0 and counting resumes on the next edge.
    task automatic clear_pulse();
        clear = 1'b1;
        wait_cycles(1);
        clear = 1'b0;
        gen_model = 4'd0;
        s = cyc;
    endtask

    // Scoreboard monitor.
    always @(negedge clock) begin
        logic [31:0] e;
        if (exp_q.size() > 0 && int'(exp_q[0][31:4]) < cyc) begin
            e = exp_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL tick_missing: no tick seen, expected one at cycle %0d gen %0d", e[31:4], e[3:0]);
        end
        if (tick === 1'b1) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL tick_unexpected: tick at cycle %0d gen %0d, expected none", cyc, generation);
            end else begin
                e = exp_q.pop_front();
                if (e !== {28'(cyc), generation}) begin
                    mismatched++;
                    $display("FAIL tick_sb: got cycle %0d gen %0d, expected cycle %0d gen %0d",
                             cyc, generation, e[31:4], e[3:0]);
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        reset = 1'b1;
        run   = 1'b0;
        step  = 1'b0;
        clear = 1'b0;
        rate  = 2'd0;

        // Reset overrides run: outputs stay 0 while reset is held.
        wait_cycles(1);
        run = 1'b1;
        wait_cycles(1);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_generation", 32'(generation), 32'd0);
        check("reset_running", 32'(running), 32'd0);

        // Free run at rate 0: 17 ticks, generation wraps 15 -> 0 on the 16th.
        reset = 1'b0;
        s = cyc;
        for (int m = 1; m <= 17; m++) push_tick(s + 16 * m);
        wait_cycles(16 * 17 + 1);
        check("freerun_generation", 32'(generation), 32'(gen_model));
        check("freerun_running", 32'(running), 32'd1);

        // Rate change mid-count: prescaler 10 at rate 0, then rate 2 and rate 3.
        clear_pulse();
        wait_cycles(10);
        rate = 2'd2;
        push_tick(s + 11);
        push_tick(s + 15);
        push_tick(s + 19);
        push_tick(s + 23);
        wait_cycles(13);
        rate = 2'd3;
        push_tick(s + 25);
        push_tick(s + 27);
        push_tick(s + 29);
        push_tick(s + 31);
        wait_cycles(9);
        check("rate_generation", 32'(generation), 32'(gen_model));
        rate = 2'd0;

        // Pause at prescaler 5, single step, then resume mid-period.
        clear_pulse();
        wait_cycles(5);
        run = 1'b0;
        wait_cycles(1);
        check("pause_running", 32'(running), 32'd0);
        wait_cycles(100);
        check("pause_generation", 32'(generation), 32'd0);
        step = 1'b1;
        push_tick(cyc + 1);
        wait_cycles(20);
        step = 1'b0;
        check("step_generation", 32'(generation), 32'd1);
        wait_cycles(2);
        run = 1'b1;
        s = cyc;
        push_tick(s + 11);
        push_tick(s + 27);
        wait_cycles(42);
        // Prescaler is at terminal now; dropping run here must suppress the tick.
        run = 1'b0;
        wait_cycles(20);
        check("runfall_generation", 32'(generation), 32'(gen_model));

        // Step toggling while running does not disturb periodic ticks.
        run = 1'b1;
        clear_pulse();
        push_tick(s + 16);
        push_tick(s + 32);
        push_tick(s + 48);
        for (int i = 0; i < 50; i++) begin
            if (i % 3 == 0) step = ~step;
            wait_cycles(1);
        end
        step = 1'b0;
        check("steprun_generation", 32'(generation), 32'(gen_model));

        // Clear collides with terminal count and is held for several cycles.
        clear_pulse();
        push_tick(s + 16);
        wait_cycles(31);
        clear = 1'b1;
        gen_model = 4'd0;
        wait_cycles(2);
        check("clear_generation", 32'(generation), 32'd0);
        wait_cycles(8);
        clear = 1'b0;
        s = cyc;
        push_tick(s + 16);
        wait_cycles(17);
        check("postclear_generation", 32'(generation), 32'd1);

        // Reset mid-operation at generation 7, prescaler 9.
        clear_pulse();
        for (int m = 1; m <= 7; m++) push_tick(s + 16 * m);
        wait_cycles(121);
        check("midop_generation", 32'(generation), 32'd7);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        check("midreset_tick", 32'(tick), 32'd0);
        check("midreset_generation", 32'(generation), 32'd0);
        check("midreset_running", 32'(running), 32'd0);
        gen_model = 4'd0;
        s = cyc;
        wait_cycles(1);
        check("resample_running", 32'(running), 32'd1);
        push_tick(s + 16);
        wait_cycles(17);
        check("postreset_generation", 32'(generation), 32'd1);

        wait_cycles(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
